// File: rtl/cpu_pkg.sv
// Shared types and encodings for the control unit and its instruction decoder.
package cpu_pkg;

  // Control FSM states
  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StAlu,
    StWriteReg
  } state_e;

  // Register-index source for readnum/writenum
  typedef enum logic [1:0] {
    NselNone,
    NselRn,
    NselRd,
    NselRm
  } nsel_e;

  // Opcode field values
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // MOV sub-op values
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // ALUop encodings; the ALU-class op field uses the same values
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // Writeback source select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: IR fields, sign-extended immediates and
// the register-index mux steered by nsel.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  input  nsel_e       nsel_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [1:0]  sh_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o,
  output logic [2:0]  rnum_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign sh_o     = ir_i[4:3];
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

  // Select which register field feeds readnum/writenum
  always_comb begin
    rnum_o = 3'b000;
    case (nsel_i)
      NselRn:  rnum_o = ir_i[10:8];
      NselRd:  rnum_o = ir_i[7:5];
      NselRm:  rnum_o = ir_i[2:0];
      default: rnum_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Instruction register, decode and one-step-per-cycle control FSM driving the datapath.
module cpu_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [1:0]  vsel,
  output logic        write,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  nsel_e       nsel;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [1:0]  sh;
  logic [2:0]  rnum;
  logic        is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

  instr_dec u_instr_dec (
    .ir_i     (ir_q),
    .nsel_i   (nsel),
    .opcode_o (opcode),
    .op_o     (op),
    .sh_o     (sh),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8),
    .rnum_o   (rnum)
  );

  assign is_mov_imm = (opcode == OP_MOV) && (op == MOV_IMM);
  assign is_mov_reg = (opcode == OP_MOV) && (op == MOV_REG);
  assign is_alu     = (opcode == OP_ALU);
  assign is_mvn     = is_alu && (op == ALU_NOT);
  assign is_cmp     = is_alu && (op == ALU_SUB);

  // Instruction register: only captures while idle, so s+load in WAIT decodes the new word
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= '0;
    end else if (load && (state_q == StWait)) begin
      ir_q <= in;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore control outputs
  always_comb begin
    state_d  = state_q;
    nsel     = NselNone;
    w        = 1'b0;
    vsel     = VSEL_C;
    write    = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    case (state_q)
      StWait: begin
        w = 1'b1;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWriteImm;
        end else if (is_mov_reg || is_mvn) begin
          state_d = StGetB;
        end else if (is_alu) begin
          state_d = StGetA;
        end else begin
          state_d = StWait;
        end
      end
      StWriteImm: begin
        nsel     = NselRn;
        writenum = rnum;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = StWait;
      end
      StGetA: begin
        nsel    = NselRn;
        readnum = rnum;
        loada   = 1'b1;
        state_d = StGetB;
      end
      StGetB: begin
        nsel    = NselRm;
        readnum = rnum;
        loadb   = 1'b1;
        state_d = StAlu;
      end
      StAlu: begin
        shift = sh;
        // Single-operand ops zero the A side so the ALU passes or inverts B
        asel  = is_mov_reg || is_mvn;
        ALUop = is_mov_reg ? ALU_ADD : op;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = StWait;
        end else begin
          loadc   = 1'b1;
          state_d = StWriteReg;
        end
      end
      StWriteReg: begin
        nsel     = NselRd;
        writenum = rnum;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = StWait;
      end
      default: state_d = StWait;
    endcase
  end

endmodule
